// File: rtl/clock_driver.sv
// Front-panel design-clock generator: divides clk into a controllable clk_out with
// free run, single step and stop-at-cycle breakpoint, plus a count of generated cycles.
module clock_driver #(
  parameter int CNT_W = 32,
  parameter int HP_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [HP_W-1:0]  half_period,
  input  logic             break_en,
  input  logic [CNT_W-1:0] break_at,
  output logic             clk_out,
  output logic             rise,
  output logic             running,
  output logic             break_hit,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [HP_W-1:0]  phase_q, phase_d;
  logic [HP_W-1:0]  term_q, term_d;
  logic             clk_out_q, clk_out_d;
  logic             rise_q, rise_d;
  logic             running_q, running_d;
  logic             break_hit_q, break_hit_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_inc;
  logic [HP_W-1:0]  hp_term;
  logic             phase_end;

  // Terminal phase count for the half period being sampled; zero behaves like one.
  assign hp_term   = (half_period == '0) ? '0 : half_period - HP_W'(1);
  assign count_inc = count_q + CNT_W'(1);
  assign phase_end = (phase_q == term_q);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    term_d      = term_q;
    clk_out_d   = clk_out_q;
    rise_d      = 1'b0;
    break_hit_d = break_hit_q;
    stop_pend_d = stop_pend_q;
    count_d     = count_q;

    case (state_q)
      S_IDLE: begin
        phase_d     = '0;
        clk_out_d   = 1'b0;
        stop_pend_d = 1'b0;
        if (run && !break_hit_q) begin
          state_d = S_RUN;
          term_d  = hp_term;
        end else if (step && !run) begin
          state_d     = S_STEP;
          term_d      = hp_term;
          break_hit_d = 1'b0;
        end
      end

      S_RUN, S_STEP: begin
        if (phase_end) begin
          phase_d   = '0;
          term_d    = hp_term;
          clk_out_d = !clk_out_q;
          if (!clk_out_q) begin
            rise_d  = 1'b1;
            count_d = count_inc;
            if (break_en && (count_inc == break_at)) begin
              break_hit_d = 1'b1;
              stop_pend_d = 1'b1;
            end
          end else begin
            // Falling toggle closes a full period: the only point a stop may take effect.
            if ((state_q == S_STEP) || !run || stop_pend_q) begin
              state_d     = S_IDLE;
              stop_pend_d = 1'b0;
            end
          end
        end else begin
          phase_d = phase_q + HP_W'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        phase_d   = '0;
        clk_out_d = 1'b0;
      end
    endcase

    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      term_q      <= '0;
      clk_out_q   <= 1'b0;
      rise_q      <= 1'b0;
      running_q   <= 1'b0;
      break_hit_q <= 1'b0;
      stop_pend_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      term_q      <= term_d;
      clk_out_q   <= clk_out_d;
      rise_q      <= rise_d;
      running_q   <= running_d;
      break_hit_q <= break_hit_d;
      stop_pend_q <= stop_pend_d;
      count_q     <= count_d;
    end
  end

  assign clk_out     = clk_out_q;
  assign rise        = rise_q;
  assign running     = running_q;
  assign break_hit   = break_hit_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_clock_driver.sv
// Bench for clock_driver: free-run vector table, step, reset, breakpoint and counter-wrap sequences.
module tb_clock_driver;

  logic        clk;
  logic        rst_n;
  logic        run, step, break_en;
  logic [15:0] half_period;
  logic [31:0] break_at;
  logic        clk_out, rise, running, break_hit;
  logic [31:0] cycle_count;

  logic        run_w;
  logic [15:0] hp_w;
  logic        clk_out_w, rise_w, running_w, break_hit_w;
  logic [3:0]  count_w;

  clock_driver #(.CNT_W(32), .HP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .half_period(half_period),
    .break_en(break_en), .break_at(break_at), .clk_out(clk_out), .rise(rise),
    .running(running), .break_hit(break_hit), .cycle_count(cycle_count)
  );

  clock_driver #(.CNT_W(4), .HP_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .step(1'b0), .half_period(hp_w),
    .break_en(1'b0), .break_at(4'd0), .clk_out(clk_out_w), .rise(rise_w),
    .running(running_w), .break_hit(break_hit_w), .cycle_count(count_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hp;
    int ticks;
    bit with_step;
    int exp_rises;
    int exp_period;
    int exp_tail;
  } vec_t;

  vec_t vec [5];
  int   sb [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   toggles = 0;
  int   run_cycles = 0;
  int   last_rise = 0;
  bit   last_valid = 0;
  int   exp_period = 0;
  int   exp_cnt = 0;
  logic prev_clk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clk cycle; at the falling edge, observe outputs and score any rise pulse.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      if (clk_out !== prev_clk) toggles++;
      prev_clk = clk_out;
      if (running === 1'b1) run_cycles++;
      else last_valid = 0;
      if (rise === 1'b1) begin
        chk("rise_with_clk_out", clk_out, 1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rise: got count %0d, expected no rise", cycle_count);
        end else begin
          chk("rise_count", cycle_count, sb.pop_front());
        end
        if (last_valid && exp_period != 0) chk("period", cyc - last_rise, exp_period);
        last_rise  = cyc;
        last_valid = 1;
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (running === 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("idle_timeout", running, 0);
  endtask

  initial begin
    int tg0, rc0, n;

    //           hp ticks step rises period tail
    vec[0] = '{2, 40, 1'b0, 10, 4, 1};
    vec[1] = '{0, 10, 1'b0,  5, 2, 1};
    vec[2] = '{3, 20, 1'b0,  4, 6, 2};
    vec[3] = '{1,  7, 1'b1,  4, 2, 2};
    vec[4] = '{4, 13, 1'b0,  2, 8, 1};

    rst_n = 1'b0;
    run = 1'b0; step = 1'b0; break_en = 1'b0; break_at = '0; half_period = '0;
    run_w = 1'b0; hp_w = 16'd1;
    #1;
    chk("reset_clk_out", clk_out, 0);
    chk("reset_rise", rise, 0);
    chk("reset_running", running, 0);
    chk("reset_break_hit", break_hit, 0);
    chk("reset_count", cycle_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("post_reset_idle", running, 0);
    chk("post_reset_clk_out", clk_out, 0);

    for (int i = 0; i < 5; i++) begin
      for (int r = 1; r <= vec[i].exp_rises; r++) sb.push_back(exp_cnt + r);
      exp_period  = vec[i].exp_period;
      half_period = 16'(vec[i].hp);
      run  = 1'b1;
      step = vec[i].with_step;
      tick();
      step = 1'b0;
      chk("start_running", running, 1);
      tick(vec[i].ticks - 1);
      tg0 = toggles;
      run = 1'b0;
      wait_idle(4 * vec[i].exp_period + 4);
      tick(3);
      exp_cnt += vec[i].exp_rises;
      chk("run_count", cycle_count, exp_cnt);
      chk("run_stop_clk_out", clk_out, 0);
      chk("run_tail_toggles", toggles - tg0, vec[i].exp_tail);
      chk("run_sb_drained", sb.size(), 0);
    end

    half_period = 16'd3;
    exp_period  = 6;
    tg0 = toggles;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(exp_cnt + 1);
      rc0  = run_cycles;
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_running", running, 1);
      if (i == 0) begin
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
      end
      wait_idle(20);
      tick(2);
      exp_cnt++;
      chk("step_duration", run_cycles - rc0, 6);
    end
    chk("step_count", cycle_count, exp_cnt);
    chk("step_toggles", toggles - tg0, 6);
    chk("step_sb_drained", sb.size(), 0);

    half_period = 16'd2;
    exp_period  = 4;
    sb.push_back(exp_cnt + 1);
    run = 1'b1;
    n = 0;
    while (clk_out !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("pre_reset_clk_out_high", clk_out, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clk_out", clk_out, 0);
    chk("async_reset_count", cycle_count, 0);
    chk("async_reset_running", running, 0);
    run = 1'b0;
    exp_cnt = 0;
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("after_reset_idle", running, 0);
    chk("after_reset_count", cycle_count, 0);
    chk("after_reset_sb_drained", sb.size(), 0);

    break_en    = 1'b1;
    break_at    = 32'd5;
    half_period = 16'd1;
    exp_period  = 2;
    for (int r = 1; r <= 5; r++) sb.push_back(r);
    run = 1'b1;
    tick();
    wait_idle(40);
    chk("brk_count", cycle_count, 5);
    chk("brk_clk_out", clk_out, 0);
    chk("brk_hit", break_hit, 1);
    chk("brk_sb_drained", sb.size(), 0);
    tick(10);
    chk("brk_run_blocked", running, 0);
    chk("brk_count_held", cycle_count, 5);
    run = 1'b0;
    tick();
    sb.push_back(6);
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("brk_step_clears", break_hit, 0);
    chk("brk_step_running", running, 1);
    wait_idle(10);
    chk("brk_step_count", cycle_count, 6);
    chk("brk_hit_stays_clear", break_hit, 0);
    break_en = 1'b0;

    run_w = 1'b1;
    tick(34);
    run_w = 1'b0;
    tick(4);
    chk("wrap_count", count_w, 1);
    chk("wrap_clk_out", clk_out_w, 0);
    chk("wrap_running", running_w, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
